// File: rtl/mdlu_iterative_pkg.sv
// Shared op codes and FSM state encoding for the iterative multiply/divide unit.
package libMdlu;

    typedef enum logic [1:0] {
        MDLU_MULT = 2'd0,
        MDLU_DIV  = 2'd1,
        MDLU_ZERO = 2'd2,
        MDLU_RSVD = 2'd3
    } mdlu_op_e;

    typedef enum logic [1:0] {
        MDLU_IDLE = 2'd0,
        MDLU_RUN  = 2'd1,
        MDLU_FIX  = 2'd2,
        MDLU_DONE = 2'd3
    } mdlu_state_e;

endpackage

// File: rtl/mdlu_iterative_if.sv
// Command/result bundle between the pipeline and the multiply/divide unit.
interface mdlu_iterative_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic               start;
    libMdlu::mdlu_op_e  op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/mdlu_iterative.sv
// Iterative signed MULT/DIV unit with HI/LO registers; one shared shift
// register and adder/subtractor serve both operations, one bit per cycle.
module mdlu_iterative
    import libMdlu::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    mdlu_iterative_if.slave bus
);

    localparam int unsigned      CNT_W     = $clog2(WIDTH);
    localparam int unsigned      PROD_W    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mdlu_state_e        state_q, state_d;
    mdlu_op_e           op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               pneg_q, pneg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               is_div;
    logic [WIDTH:0]     as_x, as_y;
    logic [WIDTH+1:0]   as_res;
    logic [PROD_W-1:0]  prod_mag, prod;
    logic [WIDTH-1:0]   quot, rem;

    assign a_mag  = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_mag  = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
    assign is_div = (op_q == MDLU_DIV);

    // Shared adder/subtractor: bit WIDTH+1 of as_res is "no borrow" when subtracting.
    always_comb begin
        if (is_div) begin
            as_x = {acc_q[WIDTH-1:0], sr_q[WIDTH-1]};
            as_y = {1'b0, m_q};
        end else begin
            as_x = acc_q;
            as_y = sr_q[0] ? {1'b0, m_q} : '0;
        end
        as_res = {1'b0, as_x} + {1'b0, (is_div ? ~as_y : as_y)} + (WIDTH+2)'(is_div);
    end

    assign prod_mag = {acc_q[WIDTH-1:0], sr_q};
    assign prod     = pneg_q ? (~prod_mag + PROD_W'(1)) : prod_mag;
    assign quot     = pneg_q ? (~sr_q + WIDTH'(1)) : sr_q;
    assign rem      = rneg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sr_d    = sr_q;
        m_d     = m_q;
        a_d     = a_q;
        b_d     = b_q;
        pneg_d  = pneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            MDLU_IDLE: begin
                if (bus.start) begin
                    if (bus.op == MDLU_MULT || bus.op == MDLU_DIV) begin
                        state_d = MDLU_RUN;
                        busy_d  = 1'b1;
                        op_d    = bus.op;
                        a_d     = bus.a;
                        b_d     = bus.b;
                        cnt_d   = '0;
                        acc_d   = '0;
                        sr_d    = a_mag;
                        m_d     = b_mag;
                        pneg_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        rneg_d  = bus.a[WIDTH-1];
                    end else if (bus.op == MDLU_ZERO) begin
                        hi_d   = '0;
                        lo_d   = '0;
                        done_d = 1'b1;
                    end
                end
            end
            MDLU_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div) begin
                    // Restoring step: keep the difference only when it did not borrow.
                    if (as_res[WIDTH+1]) begin
                        acc_d = as_res[WIDTH:0];
                        sr_d  = {sr_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = as_x;
                        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {1'b0, as_res[WIDTH:1]};
                    sr_d  = {as_res[0], sr_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = MDLU_FIX;
                end
            end
            MDLU_FIX: begin
                state_d = MDLU_DONE;
                done_d  = 1'b1;
                if (!is_div) begin
                    hi_d = prod[PROD_W-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (b_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end
            MDLU_DONE: begin
                state_d = MDLU_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = MDLU_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MDLU_IDLE;
            op_q    <= MDLU_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            sr_q    <= '0;
            m_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            m_q     <= m_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pneg_q  <= pneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/mdlu_iterative.md
MDLU_ITERATIVE -- requirements
Module: mdlu_iterative

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width and the HI/LO register width.
REQ-002 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, command strobe, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2, command code: MDLU_MULT=0, MDLU_DIV=1, MDLU_ZERO=2; code 3 is reserved.
REQ-006 The block SHALL have port a, input, WIDTH, signed rs operand (multiplicand or dividend).
REQ-007 The block SHALL have port b, input, WIDTH, signed rt operand (multiplier or divisor).
REQ-008 The block SHALL have port busy, output, 1, high while a command is in progress.
REQ-009 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have port hi, output, WIDTH, HI register, serving MFHI.
REQ-011 The block SHALL have port lo, output, WIDTH, LO register, serving MFLO.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN, FIX and DONE.
REQ-013 IDLE SHALL go to RUN when start=1 and op is MULT or DIV; this is the accept cycle (cycle 0).
REQ-014 On accept, the block SHALL latch a, b and op, store |a| and |b|, and record the result signs.
REQ-015 RUN SHALL perform exactly WIDTH iterations: shift-add for MULT, restoring shift-subtract for DIV; then go to FIX.
REQ-016 FIX SHALL apply sign correction, write hi/lo, and go to DONE.
REQ-017 DONE SHALL assert done for one cycle and return to IDLE.
REQ-018 With WIDTH=32, done SHALL be high in cycle 34 after the accept cycle.
REQ-019 busy SHALL be high from cycle 1 through the done cycle inclusive.
REQ-020 MULT SHALL produce the full 2*WIDTH signed product: {hi,lo} = a*b.
REQ-021 DIV SHALL set lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-022 DIV with b=0 SHALL complete with normal latency, giving lo = all ones and hi = a.
REQ-023 DIV of the most negative value by -1 SHALL give lo = 0x80000000 and hi = 0.
REQ-024 In IDLE, start=1 with op=ZERO SHALL clear hi and lo at the next edge and pulse done in cycle 1, with busy staying low.
REQ-025 In IDLE, start=1 with op=3 SHALL be ignored: no state change and no done pulse.
REQ-026 start SHALL be ignored whenever the state is not IDLE; there is no queuing.
REQ-027 A start in the DONE cycle SHALL be ignored.
REQ-028 hi/lo SHALL change only at the FIX-to-DONE edge or on a ZERO command; they hold their previous values while busy.
REQ-029 hi and lo SHALL be driven directly from registers, with no combinational path from a, b or op.

Reset
REQ-030 When reset_n=0 the block SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0 and all operand registers=0.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no done pulse; after release the block SHALL accept start on the first rising edge.

Structure
REQ-032 The MDLU_* op codes and the FSM state enum typedef (MDLU_IDLE, MDLU_RUN, MDLU_FIX, MDLU_DONE) SHALL live in the shared package libMdlu.
REQ-033 The iteration count SHALL be derived from WIDTH, never hard-coded.
REQ-034 The block SHALL be one module with no sub-module; a single shared shift register and adder/subtractor SHALL serve both MULT and DIV.

Verification
REQ-035 The bench SHALL cover: MULT a=7, b=-3 -> done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-036 The bench SHALL cover: MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-037 The bench SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIV a=5, b=0 -> lo=0xFFFFFFFF, hi=0x00000005.
REQ-038 The bench SHALL cover: MULT 3*4 followed by ZERO -> done in cycle 1 of the ZERO command, hi=lo=0, busy never high during the ZERO command.
REQ-039 The bench SHALL cover: DIV 100/7, then start MULT 2*2 at cycle 5 -> MULT ignored; hi/lo hold the old values until cycle 34, then lo=14 and hi=2.
REQ-040 The bench SHALL cover: MULT 9*9 with reset_n pulsed low at cycle 10 -> busy, done, hi and lo drop to 0 asynchronously; no done pulse; a new MULT 9*9 then yields lo=81.
